// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for pipeline stage registers: payload widths, exception codes, occupancy states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stage_skid_pkg;

    localparam int PC_W         = 32;
    localparam int INSTR_W      = 32;
    // pc, instr, pc+4
    localparam int STAGE_DATA_W = 2 * PC_W + INSTR_W;
    localparam int STAGE_EXC_W  = 4;

    localparam logic [STAGE_EXC_W-1:0] NO_E       = 4'h0;
    localparam logic [STAGE_EXC_W-1:0] E_FETCH    = 4'h1;
    localparam logic [STAGE_EXC_W-1:0] E_ILLEGAL  = 4'h2;
    localparam logic [STAGE_EXC_W-1:0] E_MISALIGN = 4'h3;

    // Control state is the number of held beats.
    typedef enum logic [1:0] {
        OCC_IDLE = 2'd0,
        OCC_ONE  = 2'd1,
        OCC_TWO  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat channel carrying a payload and an exception code.
// Latency: n/a (wires only).
// Backpressure: master holds valid/data/exc until the slave returns ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96,
    parameter int EXC_W  = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;

    modport master (output valid, output data, output exc, input  ready);
    modport slave  (input  valid, input  data, input  exc, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// One held beat: valid flag, payload and exception code.
// Latency: load visible one edge later; clr wins over load.
// Backpressure: none; the owner decides when to load or clear.
// Ports: clk/rst_n, clr (synchronous empty), load (capture in_dat/in_exc as valid), vld/dat/exc outputs.
module pipe_entry_reg
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = STAGE_DATA_W,
    parameter int                EXC_W  = STAGE_EXC_W,
    parameter logic [EXC_W-1:0]  NO_EXC = NO_E
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] in_dat,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              vld,
    output logic [DATA_W-1:0] dat,
    output logic [EXC_W-1:0]  exc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
            exc <= NO_EXC;
        end else if (clr) begin
            vld <= 1'b0;
            dat <= '0;
            exc <= NO_EXC;
        end else if (load) begin
            vld <= 1'b1;
            dat <= in_dat;
            exc <= in_exc;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer, flush and exception lock.
// Latency: 1 cycle from accept to o_valid_d; full throughput with downstream ready.
// Backpressure: SKID=1 ready is registered (skid empty and unlocked); SKID=0 ready = !lock & (!main | ready_d).
// Ports: i_clk, i_rst_n, i_clk_en, i_flush, i_exc_clear; up (slave beat channel), dn (master beat channel);
//        o_exc_pending (lock), o_occupancy (held beats 0..2).
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = STAGE_DATA_W,
    parameter int                EXC_W  = STAGE_EXC_W,
    parameter logic [EXC_W-1:0]  NO_EXC = NO_E,
    parameter bit                SKID   = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_en,
    input  logic                i_flush,
    input  logic                i_exc_clear,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    output logic                o_exc_pending,
    output logic [1:0]          o_occupancy
);

    logic              main_vld, skid_vld;
    logic [DATA_W-1:0] main_dat, skid_dat, main_in_dat;
    logic [EXC_W-1:0]  main_exc, skid_exc, main_in_exc;

    logic lock, lock_n;
    logic rdy_r;
    occ_e st, st_n;
    logic [1:0] cnt_n;

    logic up_rdy, accept, consume;
    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr, skid_vld_n;

    assign accept  = up.valid & up_rdy & i_clk_en;
    assign consume = main_vld & dn.ready & i_clk_en;

    // Routing of the accepted beat between main and skid.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (i_flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_vld || consume) begin
            if (skid_vld) begin
                // Older skid beat advances first to keep FIFO order.
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_load      = accept;
                skid_clr       = !accept;
            end else if (accept) begin
                main_load = 1'b1;
            end else if (consume) begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    assign main_in_dat = main_from_skid ? skid_dat : up.data;
    assign main_in_exc = main_from_skid ? skid_exc : up.exc;

    always_comb begin
        skid_vld_n = skid_vld;
        if (i_flush || skid_clr) skid_vld_n = 1'b0;
        else if (skid_load)      skid_vld_n = 1'b1;

        // A faulting accept beats a same-cycle clear.
        lock_n = lock;
        if (i_flush)                            lock_n = 1'b0;
        else if (accept && (up.exc != NO_EXC))  lock_n = 1'b1;
        else if (i_exc_clear && i_clk_en)       lock_n = 1'b0;

        cnt_n = st + {1'b0, accept} - {1'b0, consume};
        st_n  = i_flush ? OCC_IDLE : occ_e'(cnt_n);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st    <= OCC_IDLE;
            lock  <= 1'b0;
            rdy_r <= 1'b0;
        end else begin
            st    <= st_n;
            lock  <= lock_n;
            // Updated on every edge so ready rises on the first edge after reset.
            rdy_r <= !skid_vld_n && !lock_n;
        end
    end

    pipe_entry_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .NO_EXC(NO_EXC)) u_main (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (main_clr),
        .load   (main_load),
        .in_dat (main_in_dat),
        .in_exc (main_in_exc),
        .vld    (main_vld),
        .dat    (main_dat),
        .exc    (main_exc)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .NO_EXC(NO_EXC)) u_skid (
                .clk    (i_clk),
                .rst_n  (i_rst_n),
                .clr    (skid_clr),
                .load   (skid_load),
                .in_dat (up.data),
                .in_exc (up.exc),
                .vld    (skid_vld),
                .dat    (skid_dat),
                .exc    (skid_exc)
            );
            assign up_rdy = rdy_r;
        end else begin : g_pass
            assign skid_vld = 1'b0;
            assign skid_dat = '0;
            assign skid_exc = NO_EXC;
            // rdy_r is !lock once out of reset; the downstream term keeps the path combinational.
            assign up_rdy = rdy_r & (!main_vld | dn.ready);
        end
    endgenerate

    assign up.ready      = up_rdy;
    assign dn.valid      = main_vld;
    assign dn.data       = main_dat;
    assign dn.exc        = main_exc;
    assign o_exc_pending = lock;
    assign o_occupancy   = st;

endmodule
